// File: rtl/mvm_row_scheduler_if.sv
// ---------------------------------------------------------------------------
// mvm_row_scheduler_if
// Handshake bundle for the row-serial matrix-vector multiplier.
//   Job input stream  : in_valid / in_ready, matrix_inp (M rows of N elems),
//                       vector_inp (N elems), all elements DW-bit unsigned.
//   Result stream     : out_valid / out_ready, out_data (RW bits),
//                       out_row (RIW bits), out_last.
// modport master : the side that supplies jobs and consumes results.
// modport slave  : the scheduler itself.
// ---------------------------------------------------------------------------
interface mvm_row_scheduler_if #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int RW  = 2 * DW + $bits(N);
    localparam int RIW = (M > 1) ? $clog2(M) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DW*N*M-1:0]     matrix_inp;
    logic [DW*N-1:0]       vector_inp;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         out_data;
    logic [RIW-1:0]        out_row;
    logic                  out_last;

    modport master (
        output in_valid, matrix_inp, vector_inp, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last
    );

    modport slave (
        input  in_valid, matrix_inp, vector_inp, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/mvm_row_scheduler.sv
// ---------------------------------------------------------------------------
// mvm_row_scheduler
// Captures one M x N matrix and an N-element vector, then walks the rows one
// at a time through a single shared inner-product datapath, emitting each
// row's dot product on a valid/ready stream tagged with row index and last.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous abort of the current job (beats all but reset)
//   bus    : job input + result output streams (slave modport)
//   busy   : high whenever the block is not idle
//   done   : one-cycle pulse after the last row has been accepted
// ---------------------------------------------------------------------------
module mvm_row_scheduler #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    mvm_row_scheduler_if.slave   bus,
    output logic                 busy,
    output logic                 done
);
    localparam int RW  = 2 * DW + $bits(N);
    localparam int RIW = (M > 1) ? $clog2(M) : 1;
    localparam logic [RIW-1:0] LAST_ROW = RIW'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                       r_state;
    logic [M-1:0][N-1:0][DW-1:0]  r_mat;
    logic [N-1:0][DW-1:0]         r_vec;
    logic [RIW-1:0]               r_row;
    logic [RW-1:0]                r_data;
    logic [RIW-1:0]               r_out_row;
    logic                         r_valid;
    logic                         r_last;
    logic                         r_done;
    logic [RW-1:0]                w_sum;

    // Shared inner-product datapath: operands zero-extended to RW so the
    // accumulation can never overflow.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N; j++) begin
            w_sum = w_sum + (RW'(r_mat[r_row][j]) * RW'(r_vec[j]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mat     <= '0;
            r_vec     <= '0;
            r_row     <= '0;
            r_data    <= '0;
            r_out_row <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                // Abort: captured operands are simply ignored from here on.
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_row   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            r_mat   <= bus.matrix_inp;
                            r_vec   <= bus.vector_inp;
                            r_row   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        r_data    <= w_sum;
                        r_out_row <= r_row;
                        r_last    <= (r_row == LAST_ROW);
                        r_valid   <= 1'b1;
                        r_state   <= S_EMIT;
                    end
                    S_EMIT: begin
                        // Leaving EMIT always passes through CALC or IDLE, so a
                        // held-high out_ready can never accept a row twice.
                        if (bus.out_ready) begin
                            r_valid <= 1'b0;
                            if (r_row == LAST_ROW) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_row   <= r_row + 1'b1;
                                r_state <= S_CALC;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_row   = r_out_row;
    assign bus.out_last  = r_last;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

endmodule

// File: doc/mvm_row_scheduler.md
Name: mvm_row_scheduler

Overview:
Sequential matrix-vector multiplier controller. It captures one M x N matrix and one N-element vector through a valid/ready handshake, then runs the rows one at a time through a single shared inner-product datapath. Each row's dot product is emitted on a valid/ready output stream, tagged with its row index and a last flag. It replaces M parallel inner-product units where area matters more than throughput.

Parameters:
- M, 4, number of matrix rows (>=1)
- N, 4, number of columns, which is also the vector length (>=1)
- DW, 8, unsigned element width in bits
- RW (localparam), 2*DW + $bits(N), result width; same as the inner-product output width in the codebase
- RIW (localparam), max($clog2(M),1), row index width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  matrix_inp/vector_inp valid
- in_ready  output  1  block can accept a new job
- matrix_inp  input  DW*N*M  row i at [DW*N*(i+1)-1 : DW*N*i]; element j of a row at [DW*(j+1)-1 : DW*j] within the row
- vector_inp  input  DW*N  element j at [DW*(j+1)-1 : DW*j]
- clear  input  1  synchronous abort of the current job
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  RW  dot product of row out_row with the vector
- out_row  output  RIW  row index of out_data
- out_last  output  1  high with out_valid when out_row == M-1
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, row counter 0, matrix/vector registers 0, out_data 0, out_row 0, out_valid 0, out_last 0, done 0, busy 0.
- FSM states: IDLE, CALC, EMIT. in_ready = (state == IDLE). busy = !IDLE.
- IDLE: when in_valid & in_ready, register matrix_inp and vector_inp, set row=0, go to CALC. Inputs are don't-care after capture. Otherwise stay in IDLE.
- CALC (one cycle): compute the row sum as the sum over j of a[row][j]*v[j]. Operands are unsigned and zero-extended to RW; accumulation has no overflow within RW. Register the sum into out_data, row into out_row, and (row == M-1) into out_last. Set out_valid=1 and go to EMIT.
- EMIT: out_valid, out_data, out_row and out_last stay stable until out_ready.
  - On out_ready with row < M-1: out_valid=0, row+1, go to CALC.
  - On out_ready with row == M-1: out_valid=0, done=1 for the next cycle, go to IDLE.
- Timing: capture at edge T. Row r becomes valid after edge T+1+2r when out_ready is held high. M rows take 2M cycles. A new job can be captured on the edge after done asserts.
- out_ready while out_valid=0 is ignored. out_ready held high gives no double acceptance, because a CALC cycle always separates two rows.
- clear (priority over everything except reset): from any state, next edge gives state IDLE, out_valid=0, out_last=0, row=0, done stays 0. Captured data is discarded. clear in IDLE together with in_valid: the job is not captured.
- M=1: the single row has out_last=1. N=1: the result is a single product.
- Async reset mid-job: immediate return to reset values; the job is lost.

Test Plan:
- Basic (M=2,N=2,DW=2): vector_inp=4'hE, matrix_inp=8'hA7, out_ready=1 -> row0 out_data=9 out_last=0 after edge T+1; row1 out_data=10 out_last=1 after edge T+3; done pulse after T+4; in_ready back high.
- Back-pressure: same job, out_ready=0 for 5 cycles during row0 -> out_data=9, out_row=0 held stable; row1 appears 2 cycles after out_ready rises.
- Max values: all elements 3 (matrix 8'hFF, vector 4'hF) -> both rows give 18, no truncation; in_valid during busy is ignored and in_ready=0.
- Abort: assert clear during EMIT of row0 -> next cycle out_valid=0, busy=0, in_ready=1, no done; a new job with 8'hA7/4'hE then gives 9, 10.
- Async reset: drop rst_n mid-CALC -> all outputs go to reset values with no clock edge; normal job completes after release.
- Back-to-back: assert in_valid on the cycle done is high with a second job (matrix 8'h55, vector 4'h5) -> captured; results 2, 2.
